// File: rtl/vec_mem_seq_if.sv
// Bus bundle between decode/control, the vector sequencer and the memory port.
// Latency: none, wires only.
// Backpressure: none; start is a plain request pulse, memory is fixed latency.
interface vec_mem_seq_if #(
  parameter int ELEM_W   = 16,
  parameter int NUM_ELEM = 16,
  parameter int ADDR_W   = 16
);
  // control side
  logic                       start;
  logic                       is_store;
  logic [ADDR_W-1:0]          base_addr;
  logic [ELEM_W*NUM_ELEM-1:0] st_data;
  logic                       busy;
  logic                       done;
  logic                       ld_valid;
  logic [ELEM_W*NUM_ELEM-1:0] ld_data;
  // memory side
  logic [ADDR_W-1:0]          mem_addr;
  logic                       mem_rd;
  logic                       mem_wr;
  logic [ELEM_W-1:0]          mem_dout;
  logic [ELEM_W-1:0]          mem_din;

  // sequencer view
  modport slave (
    input  start, is_store, base_addr, st_data, mem_din,
    output busy, done, ld_valid, ld_data, mem_addr, mem_rd, mem_wr, mem_dout
  );

  // environment view (decode/control plus memory)
  modport master (
    output start, is_store, base_addr, st_data, mem_din,
    input  busy, done, ld_valid, ld_data, mem_addr, mem_rd, mem_wr, mem_dout
  );
endinterface

// File: rtl/vec_mem_seq.sv
// Vector load/store sequencer: moves one vector register over the element-wide memory bus.
// Latency: store done 17 cycles after start, load done/ld_valid 18 cycles after start.
// Backpressure: none; start is only sampled in IDLE, requests while busy are dropped.
module vec_mem_seq #(
  parameter int ELEM_W   = 16,
  parameter int NUM_ELEM = 16,
  parameter int ADDR_W   = 16
) (
  input  logic          clk,
  input  logic          rst,
  vec_mem_seq_if.slave  bus
);

  localparam int VEC_W = ELEM_W * NUM_ELEM;
  localparam int IDX_W = (NUM_ELEM > 1) ? $clog2(NUM_ELEM) : 1;
  localparam logic [IDX_W-1:0] LAST = IDX_W'(NUM_ELEM - 1);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    STORE     = 3'd1,
    LOAD      = 3'd2,
    LOAD_TAIL = 3'd3,
    DONE      = 3'd4
  } state_t;

  state_t            state;
  state_t            state_nxt;
  logic [IDX_W-1:0]  idx;
  logic [ADDR_W-1:0] base_q;
  logic              op_st_q;
  logic [VEC_W-1:0]  st_q;
  logic [VEC_W-1:0]  ld_q;
  logic [NUM_ELEM-1:0] ld_we;
  logic [ELEM_W-1:0] st_elem;

  // state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // request latch, element index and load assembly register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx     <= '0;
      base_q  <= '0;
      op_st_q <= 1'b0;
      st_q    <= '0;
      ld_q    <= '0;
    end else begin
      if (state == IDLE && bus.start) begin
        base_q  <= bus.base_addr;
        op_st_q <= bus.is_store;
        st_q    <= bus.st_data;
        idx     <= '0;
      end else if (state == STORE || state == LOAD) begin
        idx <= idx + 1'b1;
      end
      for (int i = 0; i < NUM_ELEM; i++) begin
        if (ld_we[i]) ld_q[ELEM_W*i +: ELEM_W] <= bus.mem_din;
      end
    end
  end

  // load write enables: read data trails mem_rd by one cycle, so element idx-1 lands now
  always_comb begin
    ld_we = '0;
    for (int i = 0; i < NUM_ELEM - 1; i++) begin
      if (state == LOAD && idx == IDX_W'(i + 1)) ld_we[i] = 1'b1;
    end
    if (state == LOAD_TAIL) ld_we[NUM_ELEM-1] = 1'b1;
  end

  // store element select from the latched vector
  always_comb begin
    st_elem = '0;
    for (int i = 0; i < NUM_ELEM; i++) begin
      if (idx == IDX_W'(i)) st_elem = st_q[ELEM_W*i +: ELEM_W];
    end
  end

  // next state and outputs, all decoded from registered state
  always_comb begin
    state_nxt    = state;
    bus.busy     = 1'b1;
    bus.done     = 1'b0;
    bus.ld_valid = 1'b0;
    bus.mem_rd   = 1'b0;
    bus.mem_wr   = 1'b0;
    bus.mem_addr = '0;
    bus.mem_dout = '0;
    case (state)
      IDLE: begin
        bus.busy = 1'b0;
        if (bus.start) state_nxt = bus.is_store ? STORE : LOAD;
      end
      STORE: begin
        bus.mem_wr   = 1'b1;
        bus.mem_addr = base_q + ADDR_W'(idx);
        bus.mem_dout = st_elem;
        if (idx == LAST) state_nxt = DONE;
      end
      LOAD: begin
        bus.mem_rd   = 1'b1;
        bus.mem_addr = base_q + ADDR_W'(idx);
        if (idx == LAST) state_nxt = LOAD_TAIL;
      end
      LOAD_TAIL: begin
        state_nxt = DONE;
      end
      DONE: begin
        bus.done     = 1'b1;
        bus.ld_valid = ~op_st_q;
        state_nxt    = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  assign bus.ld_data = ld_q;

endmodule

// File: tb/tb_vec_mem_seq.sv
// Directed bench for vec_mem_seq with a one-cycle-latency memory model.
// Latency: checks strobes, done and ld_valid cycle by cycle against hand-derived timing.
// Backpressure: exercises dropped starts while busy and back-to-back requests.
module tb_vec_mem_seq;

  logic clk;
  logic rst;
  int   n_chk;
  int   n_fail;

  vec_mem_seq_if #(.ELEM_W(16), .NUM_ELEM(16), .ADDR_W(16)) mif ();

  vec_mem_seq #(.ELEM_W(16), .NUM_ELEM(16), .ADDR_W(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (mif.slave)
  );

  // free-running clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // memory model: returns addr ^ 0x5555 the cycle after a read strobe
  always @(posedge clk or posedge rst) begin
    if (rst)             mif.mem_din <= 16'h0000;
    else if (mif.mem_rd) mif.mem_din <= mif.mem_addr ^ 16'h5555;
    else                 mif.mem_din <= 16'h0000;
  end

  task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [255:0] ld_exp(input logic [15:0] base);
    logic [255:0] r;
    r = '0;
    for (int i = 0; i < 16; i++) r[16*i +: 16] = (base + 16'(i)) ^ 16'h5555;
    return r;
  endfunction

  // pending back-to-back request, raised in the first idle cycle of the current op
  bit           nxt_vld;
  bit           nxt_st;
  logic [15:0]  nxt_base;
  logic [255:0] nxt_sd;

  task automatic all_zero(input string nm);
    chk({nm, " busy"},    256'(mif.busy),     256'd0);
    chk({nm, " done"},    256'(mif.done),     256'd0);
    chk({nm, " ldv"},     256'(mif.ld_valid), 256'd0);
    chk({nm, " rd"},      256'(mif.mem_rd),   256'd0);
    chk({nm, " wr"},      256'(mif.mem_wr),   256'd0);
    chk({nm, " addr"},    256'(mif.mem_addr), 256'd0);
    chk({nm, " dout"},    256'(mif.mem_dout), 256'd0);
    chk({nm, " ld_data"}, mif.ld_data,        256'd0);
  endtask

  // one operation: cycle 1 is the cycle after the start edge; exp_ld is the final
  // load vector for loads, or the value ld_data must keep for stores
  task automatic run_op(input string nm, input bit st, input logic [15:0] base,
                        input logic [255:0] sd, input logic [255:0] exp_ld,
                        input bit inject, input bit pre);
    int last;
    bit e_wr, e_rd, e_done, e_lv, e_busy;
    logic [15:0] e_addr, e_dout;
    last = st ? 18 : 19;
    if (!pre) begin
      @(negedge clk);
      mif.start     = 1'b1;
      mif.is_store  = st;
      mif.base_addr = base;
      mif.st_data   = sd;
    end
    @(posedge clk);
    for (int cyc = 1; cyc <= last + 1; cyc++) begin
      @(negedge clk);
      e_wr   = st  && cyc <= 16;
      e_rd   = !st && cyc <= 16;
      e_addr = (e_wr || e_rd) ? base + 16'(cyc - 1) : 16'h0000;
      e_dout = 16'h0000;
      if (e_wr) e_dout = sd[16*(cyc-1) +: 16];
      e_done = (cyc == (st ? 17 : 18));
      e_lv   = !st && e_done;
      e_busy = cyc < last;
      chk($sformatf("%s c%0d wr", nm, cyc),   256'(mif.mem_wr),   256'(e_wr));
      chk($sformatf("%s c%0d rd", nm, cyc),   256'(mif.mem_rd),   256'(e_rd));
      chk($sformatf("%s c%0d addr", nm, cyc), 256'(mif.mem_addr), 256'(e_addr));
      chk($sformatf("%s c%0d dout", nm, cyc), 256'(mif.mem_dout), 256'(e_dout));
      chk($sformatf("%s c%0d done", nm, cyc), 256'(mif.done),     256'(e_done));
      chk($sformatf("%s c%0d ldv", nm, cyc),  256'(mif.ld_valid), 256'(e_lv));
      chk($sformatf("%s c%0d busy", nm, cyc), 256'(mif.busy),     256'(e_busy));
      chk($sformatf("%s c%0d rdwr", nm, cyc), 256'(mif.mem_rd & mif.mem_wr), 256'd0);
      if (st || cyc >= 18)
        chk($sformatf("%s c%0d ld_data", nm, cyc), mif.ld_data, exp_ld);
      mif.start = 1'b0;
      if (inject && (cyc == 5 || cyc == 18)) begin
        mif.start    = 1'b1;
        mif.is_store = 1'b1;
      end
      if (cyc == last && nxt_vld) begin
        mif.start     = 1'b1;
        mif.is_store  = nxt_st;
        mif.base_addr = nxt_base;
        mif.st_data   = nxt_sd;
        nxt_vld       = 1'b0;
        break;
      end
    end
  endtask

  logic [255:0] sd_a, sd_b, sd_c, sd_d, prev_ld;

  initial begin
    n_chk = 0;
    n_fail = 0;
    nxt_vld = 1'b0;
    rst = 1'b1;
    mif.start = 1'b0;
    mif.is_store = 1'b0;
    mif.base_addr = 16'h0000;
    mif.st_data = '0;
    for (int i = 0; i < 16; i++) begin
      sd_a[16*i +: 16] = 16'hA000 + 16'(i);
      sd_b[16*i +: 16] = 16'h1100 + 16'(i);
      sd_c[16*i +: 16] = 16'hC0DE ^ 16'(i * 16'h0101);
      sd_d[16*i +: 16] = 16'h7700 + 16'(i * 3);
    end

    // reset values
    repeat (2) @(negedge clk);
    all_zero("reset");
    rst = 1'b0;

    // reset during the 5th read cycle of a load
    @(negedge clk);
    mif.start = 1'b1;
    mif.is_store = 1'b0;
    mif.base_addr = 16'h0400;
    @(posedge clk);
    for (int cyc = 1; cyc <= 5; cyc++) begin
      @(negedge clk);
      mif.start = 1'b0;
      chk($sformatf("abort c%0d rd", cyc), 256'(mif.mem_rd), 256'd1);
      chk($sformatf("abort c%0d addr", cyc), 256'(mif.mem_addr), 256'(16'h0400 + 16'(cyc - 1)));
    end
    chk("abort partial ld_data", 256'(mif.ld_data[15:0]), 256'(16'h0400 ^ 16'h5555));
    rst = 1'b1;
    #1;
    all_zero("abort async");
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      all_zero($sformatf("abort hold%0d", k));
    end
    rst = 1'b0;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      all_zero($sformatf("abort after%0d", k));
    end
    run_op("st0", 1'b1, 16'h0000, sd_b, 256'd0, 1'b0, 1'b0);

    // store from 0x0100
    run_op("st100", 1'b1, 16'h0100, sd_a, 256'd0, 1'b0, 1'b0);

    // load from 0x0200
    run_op("ld200", 1'b0, 16'h0200, '0, ld_exp(16'h0200), 1'b0, 1'b0);
    chk("ld200 elem15", 256'(mif.ld_data[255:240]), 256'(16'h020F ^ 16'h5555));

    // load wrapping through 0xFFFF
    run_op("ldwrap", 1'b0, 16'hFFF8, '0, ld_exp(16'hFFF8), 1'b0, 1'b0);
    chk("ldwrap elem8", 256'(mif.ld_data[143:128]), 256'(16'h5555));

    // starts while busy are dropped
    run_op("ldbusy", 1'b0, 16'h0500, '0, ld_exp(16'h0500), 1'b1, 1'b0);
    prev_ld = ld_exp(16'h0500);
    @(negedge clk);
    chk("ldbusy still idle", 256'(mif.busy), 256'd0);
    chk("ldbusy result kept", mif.ld_data, prev_ld);

    // back-to-back stores, second start held from the first idle cycle
    nxt_vld  = 1'b1;
    nxt_st   = 1'b1;
    nxt_base = 16'h0700;
    nxt_sd   = sd_d;
    run_op("b2b_a", 1'b1, 16'h0600, sd_c, prev_ld, 1'b0, 1'b0);
    run_op("b2b_b", 1'b1, 16'h0700, sd_d, prev_ld, 1'b0, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/vec_mem_seq.md
# vec_mem_seq

Vector load/store memory sequencer for the CVP14 datapath. On a VLD or VST it moves one 256-bit vector register (16 × 16-bit elements) across the 16-bit memory bus, one element per cycle, from consecutive addresses. It sits between the instruction decode/control logic and the memory port. Load results go to the vector register file write port; store data comes from the vector register file read port.

## Interface
Parameters:
- ELEM_W, 16, element width in bits
- NUM_ELEM, 16, elements per vector
- ADDR_W, 16, memory address width

Ports:
- clk  in  1  single clock; all state updates on rising edge
- rst  in  1  reset, asynchronous, active-high
- start  in  1  request pulse; sampled only in IDLE
- is_store  in  1  1 = VST, 0 = VLD; sampled with start
- base_addr  in  ADDR_W  address of element 0; sampled with start
- st_data  in  ELEM_W*NUM_ELEM  store vector; sampled with start
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle completion pulse
- ld_valid  out  1  one-cycle pulse with done on loads only; drives the vector RF wr_en
- ld_data  out  ELEM_W*NUM_ELEM  assembled load vector
- mem_addr  out  ADDR_W  memory address
- mem_rd  out  1  read strobe
- mem_wr  out  1  write strobe
- mem_dout  out  ELEM_W  write data
- mem_din  in  ELEM_W  read data, valid the cycle after mem_rd

## Operation
- State machine: IDLE, STORE, LOAD, LOAD_TAIL, DONE. A 4-bit index register idx counts elements.
- IDLE:
  - On start, latch base, is_store and st_data, and clear idx to 0.
  - Go to STORE if is_store is 1, otherwise go to LOAD.
- STORE:
  - mem_wr = 1, mem_addr = base + idx, mem_dout = st_data_latched[ELEM_W*idx +: ELEM_W].
  - idx increments each cycle. After idx = 15, go to DONE.
- LOAD:
  - mem_rd = 1, mem_addr = base + idx.
  - Each cycle with idx > 0, mem_din is written into element idx−1 of ld_data.
  - After idx = 15, go to LOAD_TAIL.
- LOAD_TAIL: no strobes; mem_din is written into element 15; go to DONE.
- DONE:
  - done = 1, and ld_valid = 1 if the operation was a load.
  - busy stays 1 and start is ignored. Go to IDLE.
- Element i occupies bits [16i+15:16i]. Element 0 is at base_addr.
- Address arithmetic is modulo 2^ADDR_W; base + idx wraps from 0xFFFF to 0x0000.
- ld_data holds its value until the next load overwrites it. Stores never modify ld_data.
- mem_rd and mem_wr are never high in the same cycle. Both are 0 in IDLE, LOAD_TAIL and DONE.
- start while busy = 1 is dropped, not queued.
- When no strobe is active, mem_addr and mem_dout are 0.

## Timing
- Reset values: state = IDLE, idx = 0; busy, done, ld_valid, mem_rd and mem_wr = 0; mem_addr, mem_dout and ld_data = 0.
- Reset asserted mid-operation:
  - Returns to IDLE immediately and clears ld_data.
  - No done or ld_valid is generated for the aborted operation.
  - No strobe appears after rst rises.
- Cycle 0 is the edge where start is sampled.
- Store timing:
  - Writes occur in cycles 1–16.
  - done is high in cycle 17; busy is low from cycle 18.
  - A new start is accepted at the cycle 18 edge.
- Load timing:
  - Reads occur in cycles 1–16; mem_din is captured in cycles 2–17.
  - done and ld_valid are high in cycle 18, and ld_data is complete in that cycle; busy is low from cycle 19.
- All outputs are registered or decoded from registered state only; none is combinational from inputs.

## Test plan
- Reset mid-load:
  - Stimulus: assert rst during the 5th read cycle of a load.
  - Response: all outputs 0 on the next sample, no done pulse, ld_data = 0.
  - Then start a store from base 0x0000: it completes normally.
- Store base 0x0100:
  - Stimulus: st_data element i = 0xA000+i.
  - Response: exactly 16 mem_wr cycles with mem_addr 0x0100..0x010F and mem_dout 0xA000..0xA00F in order.
  - done pulses in cycle 17 only; ld_valid stays 0.
- Load base 0x0200:
  - Stimulus: memory model returns (addr ^ 0x5555) one cycle after mem_rd.
  - Response: 16 mem_rd cycles with mem_addr 0x0200..0x020F.
  - done and ld_valid pulse together in cycle 18; element i of ld_data = (0x0200+i) ^ 0x5555.
- Wrap-around:
  - Stimulus: load from base 0xFFF8.
  - Response: mem_addr sequence 0xFFF8..0xFFFF, then 0x0000..0x0007; elements land in slots 0–15 in that order.
- Start while busy:
  - Stimulus: pulse start with is_store = 1 during a load at cycle 5, and again in the DONE cycle.
  - Response: both pulses ignored; mem_wr never asserts.
  - The load result is unchanged; busy falls in cycle 19.
- Back-to-back operations:
  - Stimulus: a store, then start held high from the first IDLE cycle.
  - Response: the second operation's strobes begin one cycle after the start edge.
  - mem_rd and mem_wr are never both high, and ld_data keeps its previous load value.
